// File: rtl/fixedpoint_pkg.sv
// rtl/fixedpoint_pkg.sv - Q4.28 constants, FSM states and the shared zoom format conversion
package fixedpoint_pkg;

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    localparam int Q_FRAC = 28;

    localparam logic signed [31:0] PI           = 32'sh3243F6A9;
    localparam logic signed [31:0] HALF_PI      = 32'sh1921FB54;
    localparam logic signed [31:0] CORDIC_INV_K = 32'sh09B74EDA;

    localparam logic signed [31:0] ATAN_TABLE [0:23] = '{
        32'sh0C90FDAA, 32'sh076B19C1, 32'sh03EB6EBF, 32'sh01FD5BAA,
        32'sh00FFAADE, 32'sh007FF557, 32'sh003FFEAB, 32'sh001FFFD5,
        32'sh000FFFFB, 32'sh0007FFFF, 32'sh00040000, 32'sh00020000,
        32'sh00010000, 32'sh00008000, 32'sh00004000, 32'sh00002000,
        32'sh00001000, 32'sh00000800, 32'sh00000400, 32'sh00000200,
        32'sh00000100, 32'sh00000080, 32'sh00000040, 32'sh00000020
    };

    // Rescale fraction bits; rounding is half-up (add half an output LSB, then floor).
    function automatic logic signed [63:0] zoom_raw(input logic signed [63:0] v, input int fin,
                                                    input int fout, input bit rnd);
        logic signed [63:0] r;
        if (fin > fout) begin
            r = v;
            if (rnd) r = r + (64'sd1 <<< (fin - fout - 1));
            r = r >>> (fin - fout);
        end else begin
            r = v <<< (fout - fin);
        end
        return r;
    endfunction

    // Rescale and clamp to a signed wout-bit code.
    function automatic logic signed [63:0] zoom(input logic signed [63:0] v, input int fin,
                                                input int fout, input int wout, input bit rnd);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = zoom_raw(v, fin, fout, rnd);
        hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wout - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

    // True when zoom had to clamp.
    function automatic logic zoom_sat(input logic signed [63:0] v, input int fin,
                                      input int fout, input int wout, input bit rnd);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = zoom_raw(v, fin, fout, rnd);
        hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wout - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/seq_cordic_rot_stage.sv
// rtl/seq_cordic_rot_stage.sv - one CORDIC rotation, combinational, indexed by iteration i
module seq_cordic_rot_stage
    import fixedpoint_pkg::*;
#(
    parameter int WR  = 18,
    parameter int WRF = 14,
    parameter int IW  = 5
) (
    input  logic signed [WR-1:0] x_in,
    input  logic signed [WR-1:0] y_in,
    input  logic signed [WR-1:0] z_in,
    input  logic [IW-1:0]        i,
    output logic signed [WR-1:0] x_out,
    output logic signed [WR-1:0] y_out,
    output logic signed [WR-1:0] z_out
);

    logic signed [WR-1:0] atan_r;
    logic signed [WR-1:0] xs;
    logic signed [WR-1:0] ys;

    // Rotate toward z=0 using the pre-update x and y.
    always_comb begin
        atan_r = WR'(zoom(64'(ATAN_TABLE[i]), Q_FRAC, WRF, WR, 1'b1));
        xs     = x_in >>> i;
        ys     = y_in >>> i;
        if (!z_in[WR-1]) begin
            x_out = x_in - ys;
            y_out = y_in + xs;
            z_out = z_in - atan_r;
        end else begin
            x_out = x_in + ys;
            y_out = y_in - xs;
            z_out = z_in + atan_r;
        end
    end

endmodule

// File: rtl/seq_fixedpoint_sincos.sv
// rtl/seq_fixedpoint_sincos.sv - multi-cycle CORDIC sin/cos; cos path built under FIXEDPOINT_SINCOS_COS_EN
module seq_fixedpoint_sincos
    import fixedpoint_pkg::*;
#(
    parameter int WII    = 4,
    parameter int WIF    = 8,
    parameter int WOI    = 2,
    parameter int WOF    = 12,
    parameter int N_ITER = 12,
    parameter int GUARD  = 2,
    parameter int ROUND  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WII+WIF-1:0]   in_angle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out_sin,
    output logic [WOI+WOF-1:0]   out_cos,
    output logic                 out_overflow
);

    localparam int WRF = ((WIF > WOF) ? WIF : WOF) + GUARD;
    localparam int WR  = 4 + WRF;
    localparam int WO  = WOI + WOF;
    localparam int IW  = 5;

    localparam logic signed [WR-1:0] PI_R    = WR'(zoom(64'(PI), Q_FRAC, WRF, WR, 1'b1));
    localparam logic signed [WR-1:0] HALF_R  = WR'(zoom(64'(HALF_PI), Q_FRAC, WRF, WR, 1'b1));
    localparam logic signed [WR-1:0] INV_K_R = WR'(zoom(64'(CORDIC_INV_K), Q_FRAC, WRF, WR, 1'b1));

    state_t state, state_nx;
    logic signed [WR-1:0] x, y, z;
    logic signed [WR-1:0] x_nx, y_nx, z_nx;
    logic [IW-1:0]        iter;
    logic                 ovf_in;
    logic signed [63:0]   ang_w;
    logic signed [WR-1:0] ang_r;
    logic signed [WR-1:0] load_z;
    logic                 ang_ovf;
    logic                 capture;
    logic [WO-1:0]        sin_c;
    logic                 sin_sat;
    logic                 cos_sat;

    seq_cordic_rot_stage #(.WR(WR), .WRF(WRF), .IW(IW)) u_rot (
        .x_in  (x),
        .y_in  (y),
        .z_in  (z),
        .i     (iter),
        .x_out (x_nx),
        .y_out (y_nx),
        .z_out (z_nx)
    );

    // Range check and quadrant fold of the incoming angle.
    always_comb begin
        ang_w   = zoom_raw(64'(signed'(in_angle)), WIF, WRF, 1'b1);
        ang_r   = WR'(ang_w);
        ang_ovf = (ang_w > 64'(PI_R)) || (ang_w < -64'(PI_R));
        load_z  = ang_r;
        if (ang_w > 64'(HALF_R)) load_z = PI_R - ang_r;
        else if (ang_w < -64'(HALF_R)) load_z = -PI_R - ang_r;
    end

    // Sin output conversion.
    always_comb begin
        sin_c   = WO'(zoom(64'(y), WRF, WOF, WO, ROUND != 0));
        sin_sat = zoom_sat(64'(y), WRF, WOF, WO, ROUND != 0);
    end

    assign capture = (state == DONE) && !out_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and input handshake.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ang_ovf ? DONE : ROT;
            end
            ROT:     if (iter == IW'(N_ITER - 1)) state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // CORDIC datapath and sin/overflow result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            z            <= '0;
            iter         <= '0;
            ovf_in       <= 1'b0;
            out_valid    <= 1'b0;
            out_sin      <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ovf_in <= ang_ovf;
                    x      <= ang_ovf ? '0 : INV_K_R;
                    y      <= '0;
                    z      <= ang_ovf ? '0 : load_z;
                    iter   <= '0;
                end
                ROT: begin
                    x    <= x_nx;
                    y    <= y_nx;
                    z    <= z_nx;
                    iter <= iter + 1'b1;
                end
                DONE: begin
                    if (capture) begin
                        out_sin      <= sin_c;
                        out_overflow <= ovf_in | sin_sat | cos_sat;
                        out_valid    <= 1'b1;
                    end else if (out_ready) begin
                        out_valid    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIXEDPOINT_SINCOS_COS_EN
    logic                 cneg;
    logic signed [WR-1:0] x_cos;
    logic [WO-1:0]        cos_c;

    // Cos sign from the fold, and the cos result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cneg    <= 1'b0;
            out_cos <= '0;
        end else begin
            if (state == IDLE && in_valid)
                cneg <= !ang_ovf && ((ang_w > 64'(HALF_R)) || (ang_w < -64'(HALF_R)));
            if (capture) out_cos <= cos_c;
        end
    end

    // Cos output conversion after undoing the fold.
    always_comb begin
        x_cos   = cneg ? -x : x;
        cos_c   = WO'(zoom(64'(x_cos), WRF, WOF, WO, ROUND != 0));
        cos_sat = zoom_sat(64'(x_cos), WRF, WOF, WO, ROUND != 0);
    end
`else
    assign cos_sat = 1'b0;
    assign out_cos = '0;
`endif

endmodule

// File: tb/tb_seq_fixedpoint_sincos.sv
// tb/tb_seq_fixedpoint_sincos.sv - directed table-driven bench for seq_fixedpoint_sincos
module tb_seq_fixedpoint_sincos;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_sin;
    logic [13:0] out_cos;
    logic        out_overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] angle;
        int          exp_sin;
        int          exp_cos;
        int          exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    seq_fixedpoint_sincos dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_angle     (in_angle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sin      (out_sin),
        .out_cos      (out_cos),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected, input int tol);
        int diff;
        checks++;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
        end
    endtask

    function automatic int cos_exp(input int c);
`ifdef FIXEDPOINT_SINCOS_COS_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input int hold);
        int cyc;
        int s0;
        int c0;
        @(negedge clk);
        check("in_ready_idle", int'(in_ready), 1, 0);
        in_angle = v.angle;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency_%03h", v.angle), cyc, v.exp_lat, 0);
        s0 = $signed(out_sin);
        c0 = $signed(out_cos);
        check($sformatf("sin_%03h", v.angle), s0, v.exp_sin, 4);
        check($sformatf("cos_%03h", v.angle), c0, cos_exp(v.exp_cos), 4);
        check($sformatf("ovf_%03h", v.angle), int'(out_overflow), v.exp_ovf, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1, 0);
            check("hold_in_ready", int'(in_ready), 0, 0);
            check("hold_sin", $signed(out_sin), s0, 0);
            check("hold_cos", $signed(out_cos), c0, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0, 0);
        check("ready_back", int'(in_ready), 1, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        vecs[0]  = '{12'h000,     0,  4096, 0, 13};
        vecs[1]  = '{12'h192,  4096,     2, 0, 13};
        vecs[2]  = '{12'hF7A, -2047,  3547, 0, 13};
        vecs[3]  = '{12'h280,  2451, -3281, 0, 13};
        vecs[4]  = '{12'h100,  3447,  2213, 0, 13};
        vecs[5]  = '{12'h193,  4096,   -14, 0, 13};
        vecs[6]  = '{12'hE6E, -4096,     2, 0, 13};
        vecs[7]  = '{12'h324,     4, -4096, 0, 13};
        vecs[8]  = '{12'hCDC,    -4, -4096, 0, 13};
        vecs[9]  = '{12'h400,     0,     0, 1, 1};
        vecs[10] = '{12'h325,     0,     0, 1, 1};
        vecs[11] = '{12'hCDB,     0,     0, 1, 1};
        vecs[12] = '{12'h800,     0,     0, 1, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_sin", int'(out_sin), 0, 0);
        check("rst_cos", int'(out_cos), 0, 0);
        check("rst_ovf", int'(out_overflow), 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], 0);

        run_vec(vecs[2], 5);

        // Busy: extra in_valid and early out_ready must not disturb the running result.
        @(negedge clk);
        in_angle = 12'h100;
        in_valid = 1'b1;
        @(negedge clk);
        in_angle  = 12'h000;
        out_ready = 1'b1;
        cyc = 0;
        seen = 0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) seen = 1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("busy_in_ready", seen, 0, 0);
        check("busy_latency", cyc, 13, 0);
        check("busy_sin", $signed(out_sin), 3447, 4);
        check("busy_cos", $signed(out_cos), cos_exp(2213), 4);
        @(negedge clk);
        out_ready = 1'b0;
        check("busy_drop", int'(out_valid), 0, 0);

        // Reset in the middle of rotations aborts without a result.
        @(negedge clk);
        in_angle = 12'h100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1, 0);
        check("abort_out_valid", int'(out_valid), 0, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_result", seen, 0, 0);

        run_vec(vecs[3], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
